// File: rtl/dmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_pkg : MMIO map and STATUS layout for the data-memory responder
// rev 1.0
// ------------------------------------------------------------------
package dmem_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

   localparam logic [11:0] OFF_CYC_LO  = 12'h000;
   localparam logic [11:0] OFF_CYC_HI  = 12'h004;
   localparam logic [11:0] OFF_TX_DATA = 12'h008;
   localparam logic [11:0] OFF_STATUS  = 12'h00C;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_COUNT_LSB = 2;
   localparam int ST_COUNT_MSB = 4;
   localparam int ST_OVF       = 5;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// tx_fifo : synchronous FIFO, head shown combinationally, zero when empty
// rev 1.0
// ------------------------------------------------------------------
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign count   = cnt;
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_responder : data RAM plus MMIO cycle counter and TX FIFO
// rev 1.0
// ------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH      = 1024,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_wen,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_i_data,
   output logic [31:0] dmem_o_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   ram [DEPTH];
   logic [63:0]   cyc;
   logic          ovf;
   logic          ram_hit;
   logic          mmio_hit;
   logic [11:0]   word_off;
   logic [IW-1:0] ram_idx;
   logic          push;
   logic          pop;
   logic          ovf_set;
   logic          ovf_clr;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [2:0]    count_sat;
   logic [31:0]   status;

   assign ram_hit  = (dmem_addr < 32'(DEPTH * 4));
   assign mmio_hit = (dmem_addr[31:12] == MMIO_BASE[31:12]);
   assign word_off = {dmem_addr[11:2], 2'b00};
   assign ram_idx  = dmem_addr[IW+1:2];

   assign push     = dmem_wen & mmio_hit & (word_off == OFF_TX_DATA);
   assign pop      = tx_valid & tx_ready;
   assign ovf_set  = push & fifo_full & ~pop;
   assign ovf_clr  = dmem_wen & mmio_hit & (word_off == OFF_STATUS) & dmem_i_data[ST_OVF];
   assign tx_valid = ~fifo_empty;

   // RAM has no reset dependency: a write in a reset cycle still commits.
   always_ff @(posedge clk) begin
      if (dmem_wen && ram_hit) begin
         ram[ram_idx] <= dmem_i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc <= '0;
         ovf <= 1'b0;
      end else begin
         cyc <= cyc + 64'd1;
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (dmem_i_data[7:0]),
      .pop       (pop),
      .head      (tx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      count_sat = 3'(fifo_count);
      if (32'(fifo_count) > 32'd7) count_sat = 3'd7;
      status                             = '0;
      status[ST_FULL]                    = fifo_full;
      status[ST_EMPTY]                   = fifo_empty;
      status[ST_COUNT_MSB:ST_COUNT_LSB]  = count_sat;
      status[ST_OVF]                     = ovf;
   end

   always_comb begin
      dmem_o_data = '0;
      if (ram_hit) begin
         dmem_o_data = ram[ram_idx];
      end else if (mmio_hit) begin
         case (word_off)
            OFF_CYC_LO: dmem_o_data = cyc[31:0];
            OFF_CYC_HI: dmem_o_data = cyc[63:32];
            OFF_STATUS: dmem_o_data = status;
            default:    dmem_o_data = '0;
         endcase
      end
   end

endmodule
`default_nettype wire
